// File: rtl/frame_buf_sched_if.sv
// Scheduler-side bus: pixel source handshake, display requests and frame buffer controls.
// With SCHED_DROP_CNT_EN defined the bus also carries the drop_cnt statistic.
interface frame_buf_sched_if #(
  parameter int OFS_WIDTH = 17
);
  logic                 frame_start;
  logic                 wr_valid;
  logic                 wr_ready;
  logic                 rd_req;
  logic                 rd_valid;
  logic                 frame_avail;
  logic                 wr_en_n;
  logic                 rd_en_n;
  logic [OFS_WIDTH:0]   wr_addr;
  logic [OFS_WIDTH:0]   rd_addr;
`ifdef SCHED_DROP_CNT_EN
  logic [15:0]          drop_cnt;
`endif

  modport master (
    output frame_start, wr_valid, rd_req,
    input  wr_ready, rd_valid, frame_avail, wr_en_n, rd_en_n, wr_addr, rd_addr
`ifdef SCHED_DROP_CNT_EN
    , input drop_cnt
`endif
  );

  modport slave (
    input  frame_start, wr_valid, rd_req,
    output wr_ready, rd_valid, frame_avail, wr_en_n, rd_en_n, wr_addr, rd_addr
`ifdef SCHED_DROP_CNT_EN
    , output drop_cnt
`endif
  );
endinterface

// File: rtl/frame_buf_sched.sv
// Ping-pong frame buffer scheduler: writer fills one bank while the reader drains the other.
// Optional SCHED_DROP_CNT_EN adds a saturating count of dropped pixels and discarded frames.
module frame_buf_sched #(
  parameter int FRAME_PIXELS = 76800,
  parameter int OFS_WIDTH    = 17
) (
  input  logic             clk,
  input  logic             reset,
  frame_buf_sched_if.slave bus
);
  typedef enum logic [1:0] {W_SYNC, W_FILL, W_WAIT} w_state_e;
  typedef enum logic       {R_IDLE, R_READ}         r_state_e;

  localparam logic [OFS_WIDTH-1:0] OFS_LAST = OFS_WIDTH'(FRAME_PIXELS - 1);

  w_state_e             w_state_q, w_state_d;
  r_state_e             r_state_q, r_state_d;
  logic [OFS_WIDTH-1:0] wr_ofs_q, wr_ofs_d, rd_ofs_q, rd_ofs_d, wr_ofs_cur;
  logic                 wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]           full_q, full_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_acc, wr_set, wr_restart, rd_acc, rd_clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state_q  <= W_SYNC;
      r_state_q  <= R_IDLE;
      wr_ofs_q   <= '0;
      rd_ofs_q   <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      wr_ofs_q   <= wr_ofs_d;
      rd_ofs_q   <= rd_ofs_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // A frame_start inside W_FILL restarts the frame; that cycle's pixel lands at offset 0.
  always_comb begin
    w_state_d  = w_state_q;
    wr_ofs_d   = wr_ofs_q;
    wr_bank_d  = wr_bank_q;
    wr_ofs_cur = wr_ofs_q;
    wr_acc     = 1'b0;
    wr_set     = 1'b0;
    wr_restart = 1'b0;
    case (w_state_q)
      W_SYNC: begin
        if (bus.frame_start) begin
          w_state_d = W_FILL;
          wr_ofs_d  = '0;
        end
      end
      W_FILL: begin
        wr_acc = bus.wr_valid;
        if (bus.frame_start) begin
          wr_ofs_cur = '0;
          wr_restart = (wr_ofs_q != '0);
        end
        wr_ofs_d = wr_ofs_cur;
        if (wr_acc) begin
          if (wr_ofs_cur == OFS_LAST) begin
            wr_set   = 1'b1;
            wr_ofs_d = '0;
            // Old full value on purpose: a same-cycle reader release costs one W_WAIT cycle.
            if (!full_q[~wr_bank_q]) begin
              wr_bank_d = ~wr_bank_q;
              w_state_d = W_SYNC;
            end else begin
              w_state_d = W_WAIT;
            end
          end else begin
            wr_ofs_d = wr_ofs_cur + OFS_WIDTH'(1);
          end
        end
      end
      W_WAIT: begin
        if (!full_q[~wr_bank_q]) begin
          wr_bank_d = ~wr_bank_q;
          w_state_d = W_SYNC;
        end
      end
      default: w_state_d = W_SYNC;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rd_ofs_d  = rd_ofs_q;
    rd_bank_d = rd_bank_q;
    rd_acc    = 1'b0;
    rd_clr    = 1'b0;
    case (r_state_q)
      R_IDLE: if (full_q[rd_bank_q]) r_state_d = R_READ;
      R_READ: begin
        rd_acc = bus.rd_req;
        if (rd_acc) begin
          if (rd_ofs_q == OFS_LAST) begin
            rd_clr    = 1'b1;
            rd_ofs_d  = '0;
            rd_bank_d = ~rd_bank_q;
            r_state_d = R_IDLE;
          end else begin
            rd_ofs_d = rd_ofs_q + OFS_WIDTH'(1);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Writer and reader never own the same bank, so set and clear hit different bits.
  always_comb begin
    full_d = full_q;
    if (wr_set) full_d[wr_bank_q] = 1'b1;
    if (rd_clr) full_d[rd_bank_q] = 1'b0;
    rd_valid_d = rd_acc;
  end

  assign bus.wr_ready    = (w_state_q == W_FILL);
  assign bus.wr_en_n     = ~wr_acc;
  assign bus.wr_addr     = {wr_bank_q, wr_ofs_cur};
  assign bus.rd_en_n     = ~rd_acc;
  assign bus.rd_addr     = {rd_bank_q, rd_ofs_q};
  assign bus.rd_valid    = rd_valid_q;
  assign bus.frame_avail = full_q[rd_bank_q];

`ifdef SCHED_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        drop_inc;

  always_comb begin
    drop_inc   = (bus.wr_valid && (w_state_q != W_FILL)) || wr_restart;
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_frame_buf_sched.sv
// Scoreboard bench for frame_buf_sched with FRAME_PIXELS=4: stimulus queues expected
// buffer addresses, a negedge monitor pops and compares whenever the DUT asserts an enable.
module tb_frame_buf_sched;
  localparam int FP  = 4;
  localparam int OFS = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [OFS:0] exp_wr[$];
  logic [OFS:0] exp_rd[$];
  logic [OFS:0] exp_rv[$];
  logic [OFS:0] last_rd_addr;

  frame_buf_sched_if #(.OFS_WIDTH(OFS)) bus ();

  frame_buf_sched #(.FRAME_PIXELS(FP), .OFS_WIDTH(OFS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: enable asserted with nothing expected at %0t", nm, $time);
  endtask

  // Inputs change 1 time unit after the rising edge and hold for one full cycle.
  task automatic step(input logic fs, input logic wv, input logic rr);
    bus.frame_start = fs;
    bus.wr_valid    = wv;
    bus.rd_req      = rr;
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0;
    bus.wr_valid    = 1'b0;
    bus.rd_req      = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!bus.wr_en_n) begin
      if (exp_wr.size() == 0) unexpected("wr_en_n");
      else check("wr_addr", 32'(bus.wr_addr), 32'(exp_wr.pop_front()));
    end
    if (bus.rd_valid) begin
      if (exp_rv.size() == 0) unexpected("rd_valid");
      else check("rd_valid_addr", 32'(last_rd_addr), 32'(exp_rv.pop_front()));
    end
    if (!bus.rd_en_n) begin
      last_rd_addr = bus.rd_addr;
      if (exp_rd.size() == 0) unexpected("rd_en_n");
      else check("rd_addr", 32'(bus.rd_addr), 32'(exp_rd.pop_front()));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.frame_start = 1'b0;
    bus.wr_valid    = 1'b1;
    bus.rd_req      = 1'b1;
    reset           = 1'b0;
    #12;
    check("rst_wr_en_n",  32'(bus.wr_en_n),     32'd1);
    check("rst_rd_en_n",  32'(bus.rd_en_n),     32'd1);
    check("rst_rd_valid", 32'(bus.rd_valid),    32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready),    32'd0);
    check("rst_avail",    32'(bus.frame_avail), 32'd0);
    check("rst_wr_addr",  32'(bus.wr_addr),     32'd0);
    check("rst_rd_addr",  32'(bus.rd_addr),     32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(0, 0, 0);

    // Fill bank 0, then start bank 1 with a single pixel.
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) begin exp_wr.push_back(3'(i)); step(0, 1, 0); end
    check("t1_avail",    32'(bus.frame_avail), 32'd1);
    check("t1_wr_ready", 32'(bus.wr_ready),    32'd0);
    step(1, 0, 0);
    check("t1_wr_addr_bank1", 32'(bus.wr_addr), 32'd4);
    exp_wr.push_back(3'd4); step(0, 1, 0);

    // Drain bank 0.
    for (int i = 0; i < 4; i++) begin
      exp_rd.push_back(3'(i)); exp_rv.push_back(3'(i)); step(0, 0, 1);
    end
    check("t2_avail",   32'(bus.frame_avail), 32'd0);
    check("t2_rd_addr", 32'(bus.rd_addr),     32'd4);

    // Restart bank 1 after two pixels; same-cycle pixel goes to offset 0.
    exp_wr.push_back(3'd5); step(0, 1, 0);
    exp_wr.push_back(3'd4); step(1, 1, 0);
    exp_wr.push_back(3'd5); step(0, 1, 0);
    exp_wr.push_back(3'd6); step(0, 1, 0);
    check("t4_avail_pending", 32'(bus.frame_avail), 32'd0);
    check("t4_wr_ready",      32'(bus.wr_ready),    32'd1);
    exp_wr.push_back(3'd7); step(0, 1, 0);
    check("t4_avail", 32'(bus.frame_avail), 32'd1);

    // Fill bank 0 while bank 1 is still full: writer must stall in W_WAIT.
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) begin exp_wr.push_back(3'(i)); step(0, 1, 0); end
    check("t3_wr_ready_wait", 32'(bus.wr_ready), 32'd0);
    step(0, 1, 0);
    step(0, 1, 0);
    check("t3_wr_ready_wait2", 32'(bus.wr_ready), 32'd0);
    for (int i = 4; i < 8; i++) begin
      exp_rd.push_back(3'(i)); exp_rv.push_back(3'(i)); step(0, 0, 1);
    end
    check("t3_wr_addr_still_wait", 32'(bus.wr_addr),     32'd0);
    check("t3_avail_bank0",        32'(bus.frame_avail), 32'd1);
    step(0, 0, 0);
    check("t3_wr_addr_bank1", 32'(bus.wr_addr), 32'd4);

    // Reset in the middle of reading bank 0.
    exp_rd.push_back(3'd0); exp_rv.push_back(3'd0); step(0, 0, 1);
    exp_rd.push_back(3'd1); step(0, 0, 1);
    bus.rd_req = 1'b1;
    reset      = 1'b0;
    #1;
    check("t5_rd_en_n",  32'(bus.rd_en_n),     32'd1);
    check("t5_rd_valid", 32'(bus.rd_valid),    32'd0);
    check("t5_avail",    32'(bus.frame_avail), 32'd0);
    check("t5_rd_addr",  32'(bus.rd_addr),     32'd0);
    check("t5_wr_addr",  32'(bus.wr_addr),     32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    check("t5_avail_after", 32'(bus.frame_avail), 32'd0);

`ifdef SCHED_DROP_CNT_EN
    check("t6_drop_rst", 32'(bus.drop_cnt), 32'd0);
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    step(1, 0, 0);
    exp_wr.push_back(3'd0); step(0, 1, 0);
    step(1, 0, 0);
    check("t6_drop_4", 32'(bus.drop_cnt), 32'd4);
    for (int i = 0; i < 4; i++) begin exp_wr.push_back(3'(i)); step(0, 1, 0); end
    for (int i = 0; i < 70000; i++) step(0, 1, 0);
    check("t6_drop_sat", 32'(bus.drop_cnt), 32'hFFFF);
`endif

    step(0, 0, 0);
    step(0, 0, 0);
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    check("rv_queue_empty", 32'(exp_rv.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
